// File: rtl/pixel_scan_ctrl.sv
// Raster-scan front/back end of the ray pipeline: issues pixel coordinates,
// realigns the returning hit bits and packs them into framebuffer words.
module pixel_scan_ctrl #(
   parameter int H_RES    = 800,
   parameter int V_RES    = 600,
   parameter int PIPE_LAT = 12,
   parameter int PACK_W   = 32,
   parameter int ADDR_W   = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [9:0]        pixel_x,
   output logic [9:0]        pixel_y,
   output logic              stall,
   input  logic              hit_in,
   output logic              fb_wr_valid,
   input  logic              fb_wr_ready,
   output logic [ADDR_W-1:0] fb_wr_addr,
   output logic [PACK_W-1:0] fb_wr_data,
   output logic              busy,
   output logic              done
);
   localparam int CNT_W = (PACK_W > 1) ? $clog2(PACK_W) : 1;
   localparam logic [9:0]       X_LAST   = 10'(H_RES - 1);
   localparam logic [9:0]       Y_LAST   = 10'(V_RES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACK_W - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   state_t              state;
   logic [PIPE_LAT-1:0] vld_sr;
   logic [PACK_W-1:0]   acc;
   logic [PACK_W-1:0]   acc_next;
   logic [CNT_W-1:0]    cnt;

   logic accept, capture, issue, last_px, word_full, flush;

   // Handshake: a word is transferred in any cycle with fb_wr_valid=1 and
   // fb_wr_ready=1; valid, addr and data stay frozen until that cycle.
   assign stall     = fb_wr_valid & ~fb_wr_ready;
   assign accept    = fb_wr_valid & fb_wr_ready;
   assign capture   = vld_sr[PIPE_LAT-1] & ~stall;
   assign issue     = (state == SCAN) & ~stall;
   assign last_px   = (pixel_x == X_LAST) && (pixel_y == Y_LAST);
   assign word_full = capture && (cnt == CNT_LAST);
   // Trailing partial word leaves only after every in-flight pixel returned.
   assign flush     = (state == DRAIN) && (vld_sr == '0) && (cnt != '0) && !stall;

   always_comb begin
      acc_next = acc;
      if (capture) acc_next[cnt] = hit_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pixel_x     <= '0;
         pixel_y     <= '0;
         vld_sr      <= '0;
         acc         <= '0;
         cnt         <= '0;
         fb_wr_valid <= 1'b0;
         fb_wr_addr  <= '0;
         fb_wr_data  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!stall) vld_sr <= PIPE_LAT'({vld_sr, issue});

         if (accept) begin
            fb_wr_valid <= 1'b0;
            fb_wr_addr  <= fb_wr_addr + 1'b1;
         end
         // A completing word may overwrite the register in its accept cycle.
         if (word_full || flush) begin
            fb_wr_valid <= 1'b1;
            fb_wr_data  <= acc_next;
            acc         <= '0;
            cnt         <= '0;
         end else if (capture) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state      <= SCAN;
                  pixel_x    <= '0;
                  pixel_y    <= '0;
                  fb_wr_addr <= '0;
                  busy       <= 1'b1;
               end
            end
            SCAN: begin
               if (issue) begin
                  if (last_px) begin
                     state <= DRAIN;
                  end else if (pixel_x == X_LAST) begin
                     pixel_x <= '0;
                     pixel_y <= pixel_y + 10'd1;
                  end else begin
                     pixel_x <= pixel_x + 10'd1;
                  end
               end
            end
            DRAIN: begin
               if ((vld_sr == '0) && (cnt == '0) && !fb_wr_valid) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Bench for pixel_scan_ctrl: an 8x4 instance with a stall-aware 3-stage
// pipeline model, plus a 5x3 instance for the partial final word.
module tb_pixel_scan_ctrl;
   localparam int H_A = 8, V_A = 4, LAT = 3, PW = 8, AW = 2;
   localparam int N_A = H_A * V_A;
   localparam int H_B = 5, V_B = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   logic          start_a = 1'b0, ready_a = 1'b1, hit_a;
   logic [9:0]    px_a, py_a;
   logic          stall_a, valid_a, busy_a, done_a;
   logic [AW-1:0] addr_a;
   logic [PW-1:0] data_a;

   logic          start_b = 1'b0, ready_b = 1'b1, hit_b = 1'b1;
   logic [9:0]    px_b, py_b;
   logic          stall_b, valid_b, busy_b, done_b;
   logic [AW-1:0] addr_b;
   logic [PW-1:0] data_b;

   int errors = 0;
   int checks = 0;

   logic           hit_tab[N_A];
   logic [2:0]     pipe_a = '0;
   logic [AW+PW-1:0] wr_q[$], wr_b_q[$], exp_q[$], saved_q[$];
   logic [19:0]    coord_q[$];
   int stall_cnt = 0, done_cnt = 0, freeze_viol = 0, done_b_cnt = 0;
   logic       prev_stall = 1'b0;
   logic [9:0] prev_x = '0;

   pixel_scan_ctrl #(.H_RES(H_A), .V_RES(V_A), .PIPE_LAT(LAT), .PACK_W(PW), .ADDR_W(AW)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .pixel_x(px_a), .pixel_y(py_a),
      .stall(stall_a), .hit_in(hit_a), .fb_wr_valid(valid_a), .fb_wr_ready(ready_a),
      .fb_wr_addr(addr_a), .fb_wr_data(data_a), .busy(busy_a), .done(done_a));

   pixel_scan_ctrl #(.H_RES(H_B), .V_RES(V_B), .PIPE_LAT(LAT), .PACK_W(PW), .ADDR_W(AW)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .pixel_x(px_b), .pixel_y(py_b),
      .stall(stall_b), .hit_in(hit_b), .fb_wr_valid(valid_b), .fb_wr_ready(ready_b),
      .fb_wr_addr(addr_b), .fb_wr_data(data_b), .busy(busy_b), .done(done_b));

   always #5 clk = ~clk;

   function automatic logic hit_of(input logic [9:0] x, input logic [9:0] y);
      int idx;
      idx = int'(y) * H_A + int'(x);
      return (idx < N_A) ? hit_tab[idx] : 1'b0;
   endfunction

   // Ray pipeline model: fixed delay that freezes together with the controller.
   always @(posedge clk) if (!stall_a) pipe_a <= {pipe_a[1:0], hit_of(px_a, py_a)};
   assign hit_a = pipe_a[2];

   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_a && ready_a) wr_q.push_back({addr_a, data_a});
         if (busy_a) coord_q.push_back({px_a, py_a});
         if (stall_a) stall_cnt <= stall_cnt + 1;
         if (done_a) done_cnt <= done_cnt + 1;
         if (prev_stall && (px_a != prev_x)) freeze_viol <= freeze_viol + 1;
         if (valid_b && ready_b) wr_b_q.push_back({addr_b, data_b});
         if (done_b) done_b_cnt <= done_b_cnt + 1;
      end
      prev_stall <= stall_a;
      prev_x     <= px_a;
   end

   task automatic fill_parity();
      for (int p = 0; p < N_A; p++) hit_tab[p] = 1'(((p % H_A) ^ (p / H_A)) & 1);
   endtask

   task automatic fill_random();
      for (int p = 0; p < N_A; p++) hit_tab[p] = 1'($urandom_range(0, 1));
   endtask

   // Reference packing: pixel p lands in word p/PW, bit p%PW; short last word.
   task automatic build_exp(input int h, input int v, input bit all_ones);
      logic [PW-1:0] w;
      int n;
      n = h * v;
      w = '0;
      exp_q.delete();
      for (int p = 0; p < n; p++) begin
         w[p % PW] = all_ones ? 1'b1 : hit_tab[p];
         if ((p % PW == PW - 1) || (p == n - 1)) begin
            exp_q.push_back({AW'(p / PW), w});
            w = '0;
         end
      end
   endtask

   // mode: 0 ready high, 1 ready toggles, 2 ready random, 3 ready low 5 cycles at first write
   task automatic run_frame(input int mode, input bit pulse_mid, output bit finished);
      int bp_left;
      int base_done;
      bp_left   = -1;
      base_done = done_cnt;
      finished  = 1'b0;
      ready_a   = (mode == 3) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         case (mode)
            1: ready_a = ~ready_a;
            2: ready_a = 1'($urandom_range(0, 1));
            3: begin
               if (bp_left < 0 && valid_a) bp_left = 5;
               else if (bp_left > 0) begin
                  bp_left--;
                  if (bp_left == 0) ready_a = 1'b1;
               end
            end
            default: ready_a = 1'b1;
         endcase
         start_a = pulse_mid && (cyc == 10);
         @(posedge clk); #1;
         if ((done_cnt != base_done) && !busy_a) begin
            finished = 1'b1;
            break;
         end
      end
      start_a = 1'b0;
      ready_a = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++; if (px_a !== 10'd0)   begin errors++; $display("FAIL reset_px: got %0d want 0", px_a); end
      checks++; if (py_a !== 10'd0)   begin errors++; $display("FAIL reset_py: got %0d want 0", py_a); end
      checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_a); end
      checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_a); end
      checks++; if (addr_a !== '0)    begin errors++; $display("FAIL reset_addr: got %0d want 0", addr_a); end
      checks++; if (data_a !== '0)    begin errors++; $display("FAIL reset_data: got %h want 00", data_a); end
      checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
      checks++; if (done_a !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done_a); end
      #20;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy_a); end
   endtask

   task automatic test_frame();
      int cb, wb, sb, db;
      bit fin;
      fill_parity();
      build_exp(H_A, V_A, 1'b0);
      cb = coord_q.size(); wb = wr_q.size(); sb = stall_cnt; db = done_cnt;
      run_frame(0, 1'b0, fin);
      checks++; if (!fin) begin errors++; $display("FAIL frame_timeout: finished=%b want 1", fin); end
      checks++; if (coord_q.size() < cb + N_A) begin errors++; $display("FAIL frame_coord_count: got %0d want >=%0d", coord_q.size() - cb, N_A); end
      else begin
         for (int i = 0; i < N_A; i++) begin
            checks++;
            if (coord_q[cb + i] !== {10'(i % H_A), 10'(i / H_A)}) begin
               errors++; $display("FAIL frame_coord[%0d]: got (%0d,%0d) want (%0d,%0d)", i, coord_q[cb + i][19:10], coord_q[cb + i][9:0], i % H_A, i / H_A);
            end
         end
      end
      checks++; if (wr_q.size() - wb != 4) begin errors++; $display("FAIL frame_write_count: got %0d want 4", wr_q.size() - wb); end
      else begin
         saved_q.delete();
         for (int i = 0; i < 4; i++) begin
            saved_q.push_back(wr_q[wb + i]);
            checks++;
            if (wr_q[wb + i] !== {AW'(i), (i % 2 == 0) ? 8'hAA : 8'h55}) begin
               errors++; $display("FAIL frame_write[%0d]: got %h want %h", i, wr_q[wb + i], {AW'(i), (i % 2 == 0) ? 8'hAA : 8'h55});
            end
            checks++;
            if (wr_q[wb + i] !== exp_q[i]) begin errors++; $display("FAIL frame_model[%0d]: got %h want %h", i, wr_q[wb + i], exp_q[i]); end
         end
      end
      checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL frame_done_count: got %0d want 1", done_cnt - db); end
      checks++; if (stall_cnt != sb) begin errors++; $display("FAIL frame_stall: got %0d want 0", stall_cnt - sb); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL frame_busy_end: got %b want 0", busy_a); end
   endtask

   task automatic test_backpressure();
      int cb, wb, sb, fb, db, n;
      logic [19:0] seq[$];
      bit fin;
      fill_parity();
      build_exp(H_A, V_A, 1'b0);
      cb = coord_q.size(); wb = wr_q.size(); sb = stall_cnt; fb = freeze_viol; db = done_cnt;
      run_frame(3, 1'b0, fin);
      checks++; if (!fin) begin errors++; $display("FAIL bp_timeout: finished=%b want 1", fin); end
      checks++; if (stall_cnt - sb != 5) begin errors++; $display("FAIL bp_stall_cycles: got %0d want 5", stall_cnt - sb); end
      checks++; if (freeze_viol != fb) begin errors++; $display("FAIL bp_freeze: got %0d moves want 0", freeze_viol - fb); end
      for (int i = cb; i < coord_q.size(); i++)
         if (seq.size() == 0 || seq[$] != coord_q[i]) seq.push_back(coord_q[i]);
      checks++; if (seq.size() != N_A) begin errors++; $display("FAIL bp_coord_count: got %0d want %0d", seq.size(), N_A); end
      else begin
         for (int i = 0; i < N_A; i++) begin
            checks++;
            if (seq[i] !== {10'(i % H_A), 10'(i / H_A)}) begin errors++; $display("FAIL bp_coord[%0d]: got %h want %h", i, seq[i], {10'(i % H_A), 10'(i / H_A)}); end
         end
      end
      n = wr_q.size() - wb;
      checks++; if (n != 4) begin errors++; $display("FAIL bp_write_count: got %0d want 4", n); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_q[wb + i] !== exp_q[i]) begin errors++; $display("FAIL bp_write[%0d]: got %h want %h", i, wr_q[wb + i], exp_q[i]); end
            if (saved_q.size() == 4) begin
               checks++;
               if (wr_q[wb + i] !== saved_q[i]) begin errors++; $display("FAIL bp_vs_free[%0d]: got %h want %h", i, wr_q[wb + i], saved_q[i]); end
            end
         end
      end
      checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL bp_done_count: got %0d want 1", done_cnt - db); end
   endtask

   task automatic test_frame_words(input string name, input int mode, input bit rand_hits);
      int wb;
      bit fin;
      if (rand_hits) fill_random(); else fill_parity();
      build_exp(H_A, V_A, 1'b0);
      wb = wr_q.size();
      run_frame(mode, 1'b0, fin);
      checks++; if (!fin) begin errors++; $display("FAIL %s_timeout: finished=%b want 1", name, fin); end
      checks++; if (wr_q.size() - wb != exp_q.size()) begin errors++; $display("FAIL %s_write_count: got %0d want %0d", name, wr_q.size() - wb, exp_q.size()); end
      else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (wr_q[wb + i] !== exp_q[i]) begin errors++; $display("FAIL %s_write[%0d]: got %h want %h", name, i, wr_q[wb + i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      test_frame_words("b2b", 1, 1'b0);
   endtask

   task automatic test_random();
      for (int f = 0; f < 3; f++) test_frame_words("rand", 2, 1'b1);
      test_frame_words("rand_b2b", 1, 1'b1);
   endtask

   task automatic test_partial();
      int wb, db, cyc;
      build_exp(H_B, V_B, 1'b1);
      wb = wr_b_q.size(); db = done_b_cnt;
      @(posedge clk); #1;
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      for (cyc = 0; cyc < 200; cyc++) begin
         @(posedge clk); #1;
         if ((done_b_cnt != db) && !busy_b) break;
      end
      checks++; if (cyc >= 200) begin errors++; $display("FAIL partial_timeout: cycles=%0d want <200", cyc); end
      checks++; if (wr_b_q.size() - wb != 2) begin errors++; $display("FAIL partial_write_count: got %0d want 2", wr_b_q.size() - wb); end
      else begin
         checks++; if (wr_b_q[wb] !== {2'd0, 8'hFF}) begin errors++; $display("FAIL partial_word0: got %h want %h", wr_b_q[wb], {2'd0, 8'hFF}); end
         checks++; if (wr_b_q[wb + 1] !== {2'd1, 8'h7F}) begin errors++; $display("FAIL partial_word1: got %h want %h", wr_b_q[wb + 1], {2'd1, 8'h7F}); end
         checks++; if (wr_b_q[wb + 1] !== exp_q[1]) begin errors++; $display("FAIL partial_model: got %h want %h", wr_b_q[wb + 1], exp_q[1]); end
      end
      checks++; if (done_b_cnt - db != 1) begin errors++; $display("FAIL partial_done: got %0d want 1", done_b_cnt - db); end
   endtask

   task automatic test_reset_mid();
      int cb, wb;
      bit fin;
      fill_parity();
      build_exp(H_A, V_A, 1'b0);
      ready_a = 1'b0;
      @(posedge clk); #1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int c = 0; c < 60 && !valid_a; c++) begin @(posedge clk); #1; end
      repeat (2) @(posedge clk);
      #3;
      checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b want 1", valid_a); end
      rst_n = 1'b0;
      #1;
      checks++; if (px_a !== 10'd0 || py_a !== 10'd0) begin errors++; $display("FAIL midrst_coord: got (%0d,%0d) want (0,0)", px_a, py_a); end
      checks++; if (valid_a !== 1'b0 || stall_a !== 1'b0) begin errors++; $display("FAIL midrst_valid_stall: got %b%b want 00", valid_a, stall_a); end
      checks++; if (addr_a !== '0 || data_a !== '0) begin errors++; $display("FAIL midrst_addr_data: got %h/%h want 0/0", addr_a, data_a); end
      checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL midrst_busy_done: got %b%b want 00", busy_a, done_a); end
      #3;
      rst_n = 1'b1;
      ready_a = 1'b1;
      cb = coord_q.size(); wb = wr_q.size();
      run_frame(0, 1'b1, fin);
      checks++; if (!fin) begin errors++; $display("FAIL restart_timeout: finished=%b want 1", fin); end
      checks++; if (coord_q.size() < cb + N_A) begin errors++; $display("FAIL restart_coord_count: got %0d want >=%0d", coord_q.size() - cb, N_A); end
      else begin
         for (int i = 0; i < N_A; i++) begin
            checks++;
            if (coord_q[cb + i] !== {10'(i % H_A), 10'(i / H_A)}) begin errors++; $display("FAIL restart_coord[%0d]: got %h want %h", i, coord_q[cb + i], {10'(i % H_A), 10'(i / H_A)}); end
         end
      end
      checks++; if (wr_q.size() - wb != 4) begin errors++; $display("FAIL restart_write_count: got %0d want 4", wr_q.size() - wb); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_q[wb + i] !== exp_q[i]) begin errors++; $display("FAIL restart_write[%0d]: got %h want %h", i, wr_q[wb + i], exp_q[i]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_backpressure();
      test_back_to_back();
      test_partial();
      test_reset_mid();
      test_random();
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pixel_scan_ctrl.md
Name: pixel_scan_ctrl

Overview:
- Front and back end of the ray pipeline: raster-scans pixel coordinates into the ray pipeline and collects the returning per-pixel hit bits.
- Drives pixel_x/pixel_y and the pipeline stall; aligns hit results to the fixed pipeline latency.
- Packs hits LSB-first into framebuffer words and writes them out over a valid/ready interface.
- Back-pressure from the framebuffer becomes pipeline stall.

Parameters:
- H_RES, 800, horizontal pixels per line
- V_RES, 600, lines per frame
- PIPE_LAT, 12, cycles from pixel_x/pixel_y issue to matching hit_in (non-stalled cycles)
- PACK_W, 32, hit bits per framebuffer word
- ADDR_W, 14, framebuffer word address width (ceil(H_RES*V_RES/PACK_W) ≤ 2^ADDR_W)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start pulse; honoured only in IDLE
- pixel_x  out  10  x coordinate issued to the pipeline
- pixel_y  out  10  y coordinate issued to the pipeline
- stall  out  1  freeze for the ray pipeline
- hit_in  in  1  hit result returning from the pipeline
- fb_wr_valid  out  1  framebuffer write request
- fb_wr_ready  in  1  framebuffer accepts the word
- fb_wr_addr  out  ADDR_W  word address
- fb_wr_data  out  PACK_W  packed hits, bit i = i-th pixel of the word
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset: async, all state cleared regardless of FSM state; takes effect mid-frame without flushing.
  - FSM to IDLE.
  - pixel_x, pixel_y, fb_wr_addr, fb_wr_data, the accumulator and the valid shift register to 0.
  - stall, fb_wr_valid, busy, done to 0.
- stall = fb_wr_valid & ~fb_wr_ready (combinational). When stall=1:
  - no coordinate advance;
  - no shift-register advance;
  - hit_in ignored.
- FSM states:
  - IDLE: start=1 goes to SCAN with x=y=0.
  - SCAN:
    - Each non-stalled cycle, the current (x,y) counts as issued and a 1 is shifted into the PIPE_LAT-deep valid shift register.
    - x increments. At x=H_RES-1, x wraps to 0 and y increments.
    - Issuing (H_RES-1, V_RES-1) goes to DRAIN; coordinates hold at the last value.
  - DRAIN: 0s shift in. Goes to DONE when the valid shift register is empty, no partial accumulator bits remain, and fb_wr_valid=0.
  - DONE: done=1 for one cycle, then IDLE.
- start in any state other than IDLE is ignored.
- Result capture: hit_in is sampled in a non-stalled cycle whose shift-register tail bit is 1. The sample goes to accumulator bit cnt, then cnt increments.
- Word output:
  - When cnt reaches PACK_W, the word loads into fb_wr_data and fb_wr_valid is set; cnt returns to 0.
  - The accumulator keeps filling while the output word waits. Stall is therefore only needed when ready is low.
- Partial final word: if the pixel count is not a multiple of PACK_W, the final word is emitted in DRAIN once the tail is empty, with upper bits zero.
- Handshake:
  - fb_wr_valid holds, with data and address stable, until the cycle where fb_wr_ready=1.
  - In that cycle fb_wr_valid clears and fb_wr_addr increments on the following cycle.
  - fb_wr_addr resets to 0 on each start.
- Simultaneous accept and new word completion in the same cycle: the new word loads and fb_wr_valid stays 1, giving back-to-back writes with no bubble.
- fb_wr_ready is ignored while fb_wr_valid=0.
- Latency: the first hit is captured PIPE_LAT non-stalled cycles after the first issue.
- busy=1 in SCAN, DRAIN, DONE.

Test Plan:
- Bench parameters: H_RES=8, V_RES=4, PIPE_LAT=3, PACK_W=8, ADDR_W=2. Pipeline model: a 3-stage delay obeying stall, with hit_in=(x^y)&1.
- Frame run, fb_wr_ready=1 constantly, start pulse:
  - coordinates go (0,0)…(7,0),(0,1)…(7,3), one per cycle;
  - 4 writes to addr 0..3, each data=8'hAA for even y and 8'h55 for odd y;
  - done pulses once; busy returns to 0.
- Back-pressure, fb_wr_ready=0 for 5 cycles at the first write:
  - stall=1 for exactly those 5 cycles;
  - pixel_x frozen during the stall;
  - final data identical to the no-backpressure run with no lost or duplicated words.
- Back-to-back accept, ready toggling 1/0 each cycle: every word written once; addresses strictly 0,1,2,3.
- Partial word, H_RES=5, V_RES=3 (15 px), all hits=1: writes 8'hFF then 8'h7F, then done.
- Reset and ignored start:
  - rst_n=0 mid-SCAN with fb_wr_valid=1: all outputs 0 immediately.
  - A new start then produces a clean frame from addr 0.
  - start pulsed during SCAN has no effect on coordinates.
